// File: rtl/vga_timing_gen_if.sv
// Video output bundle for vga_timing_gen: pixel enable in, sync/blank/position/strobes/colour out.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic          pixEn;
  logic          hSync;
  logic          vSync;
  logic          sync_n;
  logic          blank_n;
  logic [CW-1:0] nextX;
  logic [CW-1:0] nextY;
  logic          lineStart;
  logic          frameStart;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;

  modport master (
    input  pixEn,
    output hSync, vSync, sync_n, blank_n, nextX, nextY,
           lineStart, frameStart, red, green, blue
  );

  modport slave (
    output pixEn,
    input  hSync, vSync, sync_n, blank_n, nextX, nextY,
           lineStart, frameStart, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator advancing on a pixel clock-enable.
// Optional colour-bar test pattern enabled by defining VGA_TIMING_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned CW         = 12,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BP       = 64,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 23,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_ACTIVE + H_FP;
  localparam int unsigned H_SE    = H_SS + H_SYNC;
  localparam int unsigned V_SS    = V_ACTIVE + V_FP;
  localparam int unsigned V_SE    = V_SS + V_SYNC;

  if (((H_TOTAL - 1) >> CW) != 0) begin : g_h_too_big
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (((V_TOTAL - 1) >> CW) != 0) begin : g_v_too_big
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] hCnt, vCnt;
  logic [CW-1:0] h_nxt, v_nxt, x_nxt, y_nxt;
  logic [31:0]   h32, v32;
  logic          h_wrap, h_act, v_act, h_sy, v_sy;

  // Outputs are decoded from the next-state position so they line up with hCnt/vCnt.
  always_comb begin
    h_wrap = (32'(hCnt) == H_TOTAL - 1);
    h_nxt  = h_wrap ? '0 : hCnt + CW'(1);
    v_nxt  = vCnt;
    if (h_wrap) begin
      v_nxt = (32'(vCnt) == V_TOTAL - 1) ? '0 : vCnt + CW'(1);
    end
    h32   = 32'(h_nxt);
    v32   = 32'(v_nxt);
    h_act = (h32 < H_ACTIVE);
    v_act = (v32 < V_ACTIVE);
    h_sy  = (h32 >= H_SS) && (h32 < H_SE);
    v_sy  = (v32 >= V_SS) && (v32 < V_SE);
    x_nxt = h_act ? h_nxt : CW'(H_ACTIVE - 1);
    y_nxt = v_act ? v_nxt : CW'(V_ACTIVE - 1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hCnt           <= CW'(H_TOTAL - 1);
      vCnt           <= CW'(V_TOTAL - 1);
      vid.hSync      <= ~H_SYNC_POL;
      vid.vSync      <= ~V_SYNC_POL;
      vid.sync_n     <= 1'b1;
      vid.blank_n    <= 1'b0;
      vid.nextX      <= '0;
      vid.nextY      <= '0;
      vid.lineStart  <= 1'b0;
      vid.frameStart <= 1'b0;
    end else begin
      vid.lineStart  <= 1'b0;
      vid.frameStart <= 1'b0;
      if (vid.pixEn) begin
        hCnt           <= h_nxt;
        vCnt           <= v_nxt;
        vid.hSync      <= h_sy ? H_SYNC_POL : ~H_SYNC_POL;
        vid.vSync      <= v_sy ? V_SYNC_POL : ~V_SYNC_POL;
        vid.sync_n     <= ~(h_sy | v_sy);
        vid.blank_n    <= h_act & v_act;
        vid.nextX      <= x_nxt;
        vid.nextY      <= y_nxt;
        vid.lineStart  <= (h_nxt == '0);
        vid.frameStart <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar;
  logic [2:0] rgb;

  always_comb begin
    bar = 3'(32'(x_nxt) / BAR_W);
    case (bar)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vid.red   <= '0;
      vid.green <= '0;
      vid.blue  <= '0;
    end else if (vid.pixEn) begin
      vid.red   <= (rgb[2] && h_act && v_act) ? 8'hFF : 8'h00;
      vid.green <= (rgb[1] && h_act && v_act) ? 8'hFF : 8'h00;
      vid.blue  <= (rgb[0] && h_act && v_act) ? 8'hFF : 8'h00;
    end
  end
`else
  assign vid.red   = '0;
  assign vid.green = '0;
  assign vid.blue  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two small configurations (sync polarity high and low)
// checked cycle by cycle against a pixel-index reference model through a scoreboard queue.
module tb_vga_timing_gen;

  localparam int unsigned CW = 12;

  typedef struct packed {
    logic          hs, vs, sn, bn;
    logic [CW-1:0] x, y;
    logic          ls, fs;
    logic [7:0]    r, g, b;
  } outs_t;

  typedef struct packed {
    outs_t a;
    outs_t b;
  } exp_t;

  typedef struct {
    int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit          hpol, vpol;
  } cfg_t;

  cfg_t ca = '{ha:4,  hfp:1, hsw:1, hbp:1, va:3, vfp:1, vsw:1, vbp:1, hpol:1'b1, vpol:1'b1};
  cfg_t cb = '{ha:16, hfp:2, hsw:3, hbp:2, va:4, vfp:1, vsw:2, vbp:1, hpol:1'b0, vpol:1'b0};

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  vga_timing_gen_if #(.CW(CW)) ifa ();
  vga_timing_gen_if #(.CW(CW)) ifb ();

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_a (.Clock(Clock), .Reset(Reset), .vid(ifa.master));

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_b (.Clock(Clock), .Reset(Reset), .vid(ifb.master));

  always #5 Clock = ~Clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          fs_cyc[$];
  exp_t        q[$];
  int unsigned pa, pb;
  outs_t       ea, eb;

  function automatic int unsigned total(cfg_t c);
    return (c.ha + c.hfp + c.hsw + c.hbp) * (c.va + c.vfp + c.vsw + c.vbp);
  endfunction

  function automatic outs_t rst_outs(cfg_t c);
    outs_t o;
    o    = '0;
    o.hs = !c.hpol;
    o.vs = !c.vpol;
    o.sn = 1'b1;
    return o;
  endfunction

  // Position derived from a linear pixel index rather than from separate counters.
  function automatic outs_t decode(cfg_t c, int unsigned p);
    outs_t       o;
    int unsigned ht, h, v, bw, bar;
    bit          hs_on, vs_on;
    ht    = c.ha + c.hfp + c.hsw + c.hbp;
    h     = p % ht;
    v     = p / ht;
    hs_on = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
    vs_on = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
    o     = '0;
    o.hs  = hs_on ? c.hpol : !c.hpol;
    o.vs  = vs_on ? c.vpol : !c.vpol;
    o.sn  = !(hs_on || vs_on);
    o.bn  = (h < c.ha) && (v < c.va);
    o.x   = CW'((h < c.ha) ? h : c.ha - 1);
    o.y   = CW'((v < c.va) ? v : c.va - 1);
    o.ls  = (h == 0);
    o.fs  = (p == 0);
    bw    = c.ha / 8;
    if (bw == 0) bw = 1;
    bar   = h / bw;
`ifdef VGA_TIMING_PATTERN_EN
    if (o.bn) begin
      o.r = (bar inside {0, 1, 4, 5}) ? 8'hFF : 8'h00;
      o.g = (bar < 4)                 ? 8'hFF : 8'h00;
      o.b = (bar % 2 == 0)            ? 8'hFF : 8'h00;
    end
`endif
    return o;
  endfunction

  task automatic step(input bit rst, input bit en);
    exp_t  e;
    outs_t oa, ob;
    Reset     = rst;
    ifa.pixEn = en;
    ifb.pixEn = en;
    if (rst) begin
      pa = total(ca) - 1;
      pb = total(cb) - 1;
      ea = rst_outs(ca);
      eb = rst_outs(cb);
    end else if (en) begin
      pa = (pa + 1) % total(ca);
      pb = (pb + 1) % total(cb);
      ea = decode(ca, pa);
      eb = decode(cb, pb);
    end else begin
      ea.ls = 1'b0; ea.fs = 1'b0;
      eb.ls = 1'b0; eb.fs = 1'b0;
    end
    e.a = ea;
    e.b = eb;
    q.push_back(e);
    @(posedge Clock);
    #1;
    cyc++;
    e  = q.pop_front();
    oa = {ifa.hSync, ifa.vSync, ifa.sync_n, ifa.blank_n, ifa.nextX, ifa.nextY,
          ifa.lineStart, ifa.frameStart, ifa.red, ifa.green, ifa.blue};
    ob = {ifb.hSync, ifb.vSync, ifb.sync_n, ifb.blank_n, ifb.nextX, ifb.nextY,
          ifb.lineStart, ifb.frameStart, ifb.red, ifb.green, ifb.blue};
    n_tests++;
    assert (oa === e.a) else begin
      n_fail++;
      $error("FAIL outs_a cyc=%0d got %h exp %h", cyc, oa, e.a);
    end
    n_tests++;
    assert (ob === e.b) else begin
      n_fail++;
      $error("FAIL outs_b cyc=%0d got %h exp %h", cyc, ob, e.b);
    end
    if (oa.fs === 1'b1) fs_cyc.push_back(cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.pixEn = 1'b0;
    ifb.pixEn = 1'b0;

    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    step(1'b0, 1'b1);
    n_tests++;
    assert (ifa.frameStart === 1'b1 && ifa.lineStart === 1'b1) else begin
      n_fail++;
      $error("FAIL first_strobes got fs=%b ls=%b exp fs=1 ls=1", ifa.frameStart, ifa.lineStart);
    end

    for (int i = 0; i < 200; i++) step(1'b0, (i % 2) == 1);
    n_tests++;
    assert (fs_cyc.size() >= 3) else begin
      n_fail++;
      $error("FAIL fs_count got %0d exp >=3", fs_cyc.size());
    end
    if (fs_cyc.size() >= 3) begin
      n_tests++;
      assert (fs_cyc[1] - fs_cyc[0] == 84) else begin
        n_fail++;
        $error("FAIL fs_period0 got %0d exp 84", fs_cyc[1] - fs_cyc[0]);
      end
      n_tests++;
      assert (fs_cyc[2] - fs_cyc[1] == 84) else begin
        n_fail++;
        $error("FAIL fs_period1 got %0d exp 84", fs_cyc[2] - fs_cyc[1]);
      end
    end

    for (int i = 0; i < 100; i++) step(1'b0, 1'b1);

    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n_tests++;
    assert (ifa.frameStart === 1'b1 && ifa.nextX === '0 && ifa.nextY === '0) else begin
      n_fail++;
      $error("FAIL post_reset got fs=%b x=%0d y=%0d exp fs=1 x=0 y=0",
             ifa.frameStart, ifa.nextX, ifa.nextY);
    end

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA raster timing generator that replaces the fixed 800x600 controller.
- Horizontal and vertical active, porch and sync lengths are parameters; sync polarity is selectable.
- Advances on a pixel clock-enable, so one system clock serves several pixel rates.
- Emits line-start and frame-start strobes, and optionally a colour-bar test pattern.
- Sits between the system clock domain and the DAC/video pins; downstream frame-buffer readers use nextX/nextY and the strobes.

Parameters:
CW, 12, counter and coordinate width; elaboration error if H_TOTAL or V_TOTAL > 2**CW
H_ACTIVE, 800, visible pixels per line; must be a multiple of 8
H_FP, 56, horizontal front porch pixels (>=1)
H_SYNC, 120, horizontal sync pixels (>=1)
H_BP, 64, horizontal back porch pixels (>=1); H_TOTAL = sum = 1040
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch lines (>=1)
V_SYNC, 6, vertical sync lines (>=1)
V_BP, 23, vertical back porch lines (>=1); V_TOTAL = sum = 666
H_SYNC_POL, 1, level of hSync during the sync pulse
V_SYNC_POL, 1, level of vSync during the sync pulse

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
pixEn  in  1  pixel advance enable; counters and outputs update only on edges with pixEn=1
hSync  out  1  horizontal sync, polarity per H_SYNC_POL
vSync  out  1  vertical sync, polarity per V_SYNC_POL
sync_n  out  1  composite sync, low while either sync pulse is active
blank_n  out  1  high only inside the active area
nextX  out  CW  active column; holds H_ACTIVE-1 outside the active columns
nextY  out  CW  active row; holds V_ACTIVE-1 outside the active rows
lineStart  out  1  one-Clock pulse on entering hCnt=0
frameStart  out  1  one-Clock pulse on entering (0,0)
red, green, blue  out  8 each  test pattern (see Optional Feature)

Behaviour:
- Internal counters: hCnt (0..H_TOTAL-1) and vCnt (0..V_TOTAL-1).
- On an edge with pixEn=1:
  - hCnt increments.
  - At H_TOTAL-1, hCnt wraps to 0 and vCnt increments.
  - When vCnt is at V_TOTAL-1 and hCnt wraps, vCnt also wraps to 0.
- Reset (dominates pixEn):
  - hCnt=H_TOTAL-1, vCnt=V_TOTAL-1.
  - hSync=!H_SYNC_POL, vSync=!V_SYNC_POL, sync_n=1, blank_n=0.
  - nextX=0, nextY=0, lineStart=0, frameStart=0, colours=0.
  - The first enabled edge after reset enters (0,0) and pulses frameStart and lineStart.
- All outputs are registered from the next-state counter values, so during any cycle they describe the position held in hCnt/vCnt. Latency from position to output is 0 cycles relative to the counters.
- Level outputs hold their value across cycles with pixEn=0.
- lineStart and frameStart are high for exactly one Clock cycle after the enabled edge, even when pixEn stays low afterwards.
- Horizontal sync is active when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC. Vertical sync is decoded the same way on vCnt.
- blank_n = (hCnt < H_ACTIVE) AND (vCnt < V_ACTIVE).
- nextX = hCnt when hCnt < H_ACTIVE, else H_ACTIVE-1. nextY follows the same rule on vCnt.
- Reset asserted mid-frame takes effect on the next Clock edge and discards the current position.

Optional Feature:
VGA_TIMING_PATTERN_EN
- Defined:
  - red/green/blue show 8 vertical bars of width H_ACTIVE/8, with bar = nextX/(H_ACTIVE/8).
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 8'hFF or 8'h00.
  - Colours are 0 whenever blank_n=0.
  - Colours are registered with the same timing as blank_n.
- Undefined: red/green/blue are constant 0; ports remain present.

Test Plan:
- Defaults, pixEn=1 constant, release Reset -> frameStart high the first cycle; next frameStart exactly 692640 cycles later; lineStart every 1040 cycles.
- Defaults, pixEn=1 -> per line, hSync=1 for positions 856..975 (120 cycles); vSync=1 for lines 637..642; sync_n low in both windows; blank_n high for 800 cycles on lines 0..599 only.
- H=4/1/1/1, V=3/1/1/1, pixEn toggling every cycle -> frameStart period 2*7*6=84 cycles; each strobe is 1 cycle wide; nextX sequence 0,1,2,3,3,3,3; nextY holds 2 on lines 3..5.
- Reset asserted at hCnt=500, vCnt=300 for 1 cycle -> next cycle outputs at reset values; next enabled edge gives frameStart=1 and nextX=nextY=0.
- H_SYNC_POL=0, V_SYNC_POL=0 -> hSync/vSync idle high and pulse low; sync_n unchanged.
- VGA_TIMING_PATTERN_EN defined, defaults -> x=0..99 gives FF/FF/FF, x=100 gives FF/FF/00, x=700..799 gives 00/00/00, and 0 during blanking.
